// File: rtl/bla_subtractor_pipe_if.sv
// rtl/bla_subtractor_pipe_if.sv - operand/result handshake bundle for the pipelined subtractor
interface bla_subtractor_pipe_if #(
    parameter int W = 5
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf, zero
    );
endinterface

// File: rtl/bla_subtractor_pipe.sv
// rtl/bla_subtractor_pipe.sv - two-stage borrow-lookahead subtractor {bout,d} = a - b - bin
// Stage 1 registers per-bit generate/propagate terms; stage 2 resolves borrows and flags.
module bla_subtractor_pipe #(
    parameter int W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    bla_subtractor_pipe_if.slave     bus
);
    logic         s1_valid;
    logic         s2_valid;
    logic [W-1:0] g_q;
    logic [W-1:0] p_q;
    logic [W-1:0] x_q;
    logic         bin_q;
    logic         a_msb_q;
    logic         b_msb_q;

    logic [W-1:0] d_q;
    logic         bout_q;
    logic         ovf_q;
    logic         zero_q;

    logic         adv2;
    logic [W:0]   c;
    logic [W-1:0] d_n;
    logic         ovf_n;

    assign adv2         = s1_valid & (~s2_valid | bus.out_ready);
    assign bus.in_ready = ~s1_valid | adv2;

    // Each borrow is an independent OR of products over g/p, so no borrow depends on another.
    always_comb begin : lookahead
        logic term;
        c    = '0;
        term = 1'b0;
        c[0] = bin_q;
        for (int i = 0; i < W; i++) begin
            term = bin_q;
            for (int k = 0; k <= i; k++) term = term & p_q[k];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g_q[j];
                for (int k = j + 1; k <= i; k++) term = term & p_q[k];
                c[i+1] = c[i+1] | term;
            end
        end
    end

    assign d_n   = x_q ^ c[W-1:0];
    assign ovf_n = (a_msb_q ^ b_msb_q) & (d_n[W-1] ^ a_msb_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            g_q      <= '0;
            p_q      <= '0;
            x_q      <= '0;
            bin_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                g_q     <= ~bus.a & bus.b;
                p_q     <= ~(bus.a ^ bus.b);
                x_q     <= bus.a ^ bus.b;
                bin_q   <= bus.bin;
                a_msb_q <= bus.a[W-1];
                b_msb_q <= bus.b[W-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (adv2) begin
            s2_valid <= 1'b1;
            d_q      <= d_n;
            bout_q   <= c[W];
            ovf_q    <= ovf_n;
            zero_q   <= ~|d_n;
        end else if (bus.out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.d         = d_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_bla_subtractor_pipe.sv
// tb/tb_bla_subtractor_pipe.sv - scoreboard bench for bla_subtractor_pipe
module tb_bla_subtractor_pipe;
    localparam int W = 5;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    res_t q[$];
    bit   rand_done;
    bit   held;
    res_t held_val;

    always #5 clk = ~clk;

    bla_subtractor_pipe_if #(.W(W)) bus ();

    bla_subtractor_pipe #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic res_t model(input int a, input int b, input int bin);
        res_t r;
        int diff, sa, sb, sd;
        diff = a - b - bin;
        sa   = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb   = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        sd   = sa - sb - bin;
        r.d    = W'(diff + (1 << (W + 1)));
        r.bout = (diff < 0);
        r.ovf  = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
        r.zero = (r.d == '0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t out_now();
        res_t r;
        r.d    = bus.d;
        r.bout = bus.bout;
        r.ovf  = bus.ovf;
        r.zero = bus.zero;
        return r;
    endfunction

    // Offers one operand set until accepted; returns after the accepting edge.
    task automatic send(input int a, input int b, input int bin, output int stalls);
        bit ok;
        stalls = 0;
        ok     = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a        = W'(a);
            bus.b        = W'(b);
            bus.bin      = 1'(bin);
            #4;
            if (bus.in_ready) begin
                q.push_back(model(a, b, bin));
                ok = 1;
            end else begin
                stalls++;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && q.size() != 0; n++) @(negedge clk);
        chk("drain_empty", q.size(), 0);
        @(negedge clk);
    endtask

    always begin
        @(negedge clk);
        #4;
        if (!rst && bus.out_valid) begin
            if (bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    chk("result", 32'(out_now()), 32'(q.pop_front()));
                end
                held = 0;
            end else begin
                if (held) chk("stall_hold", 32'(out_now()), 32'(held_val));
                held     = 1;
                held_val = out_now();
            end
        end else begin
            held = 0;
        end
    end

    int st;
    int stl[4];

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_outputs", 32'(out_now()), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("reset_in_ready", bus.in_ready, 1);

        send(12, 19, 0, st);
        @(negedge clk);
        chk("latency_not_early", bus.out_valid, 0);
        @(negedge clk);
        chk("latency_two", bus.out_valid, 1);
        chk("basic_value", 32'(out_now()), 32'({5'd25, 1'b1, 1'b1, 1'b0}));
        drain();

        send(12, 19, 1, st);
        send(9, 27, 1, st);
        send(31, 31, 0, st);
        send(0, 0, 1, st);
        drain();

        bus.out_ready = 1'b0;
        fork
            begin
                repeat (5) @(negedge clk);
                bus.out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 4; i++) send($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1), stl[i]);
            end
        join
        chk("bp_accept1_free", stl[0], 0);
        chk("bp_accept2_free", stl[1], 0);
        chk("bp_third_stalled", stl[2] > 0, 1);
        for (int i = 0; i < 4 && q.size() != 0; i++) begin
            @(negedge clk);
            #4 chk("bp_stream_valid", bus.out_valid, 1);
        end
        drain();

        bus.out_ready = 1'b0;
        send(3, 7, 0, st);
        send(20, 1, 1, st);
        @(negedge clk);
        chk("pre_reset_full", {bus.out_valid, bus.in_ready}, 2'b10);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_outputs", 32'(out_now()), 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1 chk("post_reset_in_ready", bus.in_ready, 1);
        repeat (3) begin
            @(negedge clk);
            chk("no_stale_result", bus.out_valid, 0);
        end

        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1), st);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
        repeat (3) @(negedge clk);
        chk("final_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
